// File: rtl/sprite_bus_arbiter_pkg.sv
// Shared IO map, status layout and slot-owner encoding for the sprite RAM arbiter.
// Also carries the CPU data width used across the stack machine.
package sprite_bus_arbiter_pkg;

    localparam int unsigned CPU_WIDTH_DEFAULT = 16;
    localparam int unsigned RAM_AW            = 9;

    localparam logic [15:0] SPRITE_WIN_BASE = 16'h4000;
    localparam logic [15:0] STATUS_ADDR     = 16'h8000;
    localparam logic [15:0] CLEAR_ADDR      = 16'h8001;

    localparam int unsigned STATUS_DROP_LSB  = 8;
    localparam int unsigned STATUS_FULL_BIT  = 7;
    localparam int unsigned STATUS_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_VIDEO,
        SLOT_DRAIN,
        SLOT_FORCE
    } slot_e;

    // The window is 512 words, so only the upper seven address bits select it.
    function automatic logic in_sprite_window(input logic [15:0] addr);
        return addr[15:9] == SPRITE_WIN_BASE[15:9];
    endfunction

    function automatic logic [15:0] pack_status(input logic [7:0] drop_count,
                                                input logic       full,
                                                input logic [3:0] count);
        logic [15:0] s;
        s = '0;
        s[STATUS_DROP_LSB +: 8]  = drop_count;
        s[STATUS_FULL_BIT]       = full;
        s[STATUS_COUNT_LSB +: 4] = count;
        return s;
    endfunction

endpackage

// File: rtl/sprite_bus_arbiter_posted_write_fifo.sv
// Posted-write FIFO holding {ram address, data} entries for the sprite RAM.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module posted_write_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sprite_bus_arbiter.sv
// Arbitrates the single-port sprite RAM between renderer fetches and posted CPU writes,
// with a starvation guard and a CPU-visible status register.
module sprite_bus_arbiter
    import sprite_bus_arbiter_pkg::*;
#(
    parameter int unsigned CPU_WIDTH    = CPU_WIDTH_DEFAULT,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CPU_WIDTH-1:0] io_addr,
    input  logic                 io_write,
    input  logic [CPU_WIDTH-1:0] io_wr_data,
    output logic [CPU_WIDTH-1:0] io_rd_data,
    input  logic                 vid_req,
    input  logic [8:0]           vid_addr,
    output logic                 vid_gnt,
    output logic                 vid_rd_valid,
    output logic [CPU_WIDTH-1:0] vid_rd_data,
    output logic [8:0]           ram_addr,
    output logic                 ram_we,
    output logic [CPU_WIDTH-1:0] ram_wr_data,
    input  logic [CPU_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned EW = RAM_AW + CPU_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [EW-1:0]        fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 push_req;
    logic                 clear_wr;
    logic                 drop;
    slot_e                slot;

    logic [7:0]           drop_count_q, drop_count_d;
    logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
    logic                 vid_rd_valid_q, vid_rd_valid_d;

    assign push_req = io_write && in_sprite_window(io_addr[15:0]);
    assign clear_wr = io_write && (io_addr == CPU_WIDTH'(CLEAR_ADDR));
    assign drop     = push_req && fifo_full && !fifo_pop;

    posted_write_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data ({io_addr[RAM_AW-1:0], io_wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        slot        = SLOT_IDLE;
        vid_gnt     = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        fifo_pop    = 1'b0;
        if (starve_cnt_q == STARVE_MAX && !fifo_empty) begin
            slot = SLOT_FORCE;
        end else if (vid_req) begin
            slot = SLOT_VIDEO;
        end else if (!fifo_empty) begin
            slot = SLOT_DRAIN;
        end
        case (slot)
            SLOT_FORCE, SLOT_DRAIN: begin
                ram_we      = 1'b1;
                ram_addr    = fifo_head[EW-1 -: RAM_AW];
                ram_wr_data = fifo_head[CPU_WIDTH-1:0];
                fifo_pop    = 1'b1;
            end
            SLOT_VIDEO: begin
                vid_gnt  = 1'b1;
                ram_addr = vid_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (clear_wr) begin
            drop_count_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        starve_cnt_d = starve_cnt_q;
        if (fifo_pop || !fifo_full) begin
            starve_cnt_d = '0;
        end else if (vid_req && slot != SLOT_FORCE && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        vid_rd_valid_d = vid_gnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_q   <= '0;
            starve_cnt_q   <= '0;
            vid_rd_valid_q <= 1'b0;
        end else begin
            drop_count_q   <= drop_count_d;
            starve_cnt_q   <= starve_cnt_d;
            vid_rd_valid_q <= vid_rd_valid_d;
        end
    end

    assign vid_rd_valid = vid_rd_valid_q;
    assign vid_rd_data  = vid_rd_valid_q ? ram_rd_data : '0;

    always_comb begin
        io_rd_data = '0;
        if (io_addr == CPU_WIDTH'(STATUS_ADDR)) begin
            io_rd_data = CPU_WIDTH'(pack_status(drop_count_q, fifo_full, 4'(fifo_count)));
        end
    end

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Directed bench for sprite_bus_arbiter with a behavioural one-cycle-read sprite RAM.
module tb_sprite_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] io_addr;
    logic        io_write;
    logic [15:0] io_wr_data;
    logic [15:0] io_rd_data;
    logic        vid_req;
    logic [8:0]  vid_addr;
    logic        vid_gnt;
    logic        vid_rd_valid;
    logic [15:0] vid_rd_data;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wr_data;
    logic [15:0] ram_rd_data;

    logic [15:0] ram_mem [512];

    int n_checks = 0;
    int n_errors = 0;

    sprite_bus_arbiter #(
        .CPU_WIDTH    (16),
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_addr      (io_addr),
        .io_write     (io_write),
        .io_wr_data   (io_wr_data),
        .io_rd_data   (io_rd_data),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_gnt      (vid_gnt),
        .vid_rd_valid (vid_rd_valid),
        .vid_rd_data  (vid_rd_data),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= ram_mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic io_idle();
        io_write   = 1'b0;
        io_addr    = 16'h8000;
        io_wr_data = 16'h0000;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [15:0] data);
        io_write   = 1'b1;
        io_addr    = addr;
        io_wr_data = data;
    endtask

    logic [15:0] pre_data [3];
    logic [8:0]  force_addr [4];
    int          last_force;
    int          n_force;

    initial begin
        pre_data   = '{16'h7007, 16'h8008, 16'h9009};
        force_addr = '{9'h021, 9'h022, 9'h023, 9'h030};

        reset    = 1'b1;
        vid_req  = 1'b1;
        vid_addr = 9'h003;
        io_idle();
        tick();
        tick();
        #1;
        check_eq("rst_rd_valid", vid_rd_valid, 0);
        check_eq("rst_status", io_rd_data, 16'h0000);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_gnt_follows_req", vid_gnt, 1);

        // Idle drain
        reset   = 1'b0;
        vid_req = 1'b0;
        io_wr(16'h4005, 16'h1234);
        #1;
        check_eq("t1_win_read_zero", io_rd_data, 16'h0000);
        check_eq("t1_no_write_yet", ram_we, 0);
        tick();
        io_idle();
        #1;
        check_eq("t1_ram_we", ram_we, 1);
        check_eq("t1_ram_addr", ram_addr, 9'h005);
        check_eq("t1_ram_data", ram_wr_data, 16'h1234);
        check_eq("t1_status_cnt1", io_rd_data, 16'h0001);
        tick();
        #1;
        check_eq("t1_status_empty", io_rd_data, 16'h0000);
        check_eq("t1_we_idle", ram_we, 0);

        // Preload words 7..9 through the FIFO for the fetch test
        for (int i = 0; i < 3; i++) begin
            io_wr(16'h4007 + 16'(i), pre_data[i]);
            tick();
        end
        io_idle();
        #1;
        check_eq("pre_last_we", ram_we, 1);
        check_eq("pre_last_addr", ram_addr, 9'h009);
        check_eq("pre_last_data", ram_wr_data, 16'h9009);
        tick();

        // Video priority
        vid_req  = 1'b1;
        vid_addr = 9'h007;
        io_wr(16'h4010, 16'hA1A1);
        tick();
        io_wr(16'h4011, 16'hA2A2);
        tick();
        io_idle();
        #1;
        check_eq("t2_status_cnt2", io_rd_data, 16'h0002);
        check_eq("t2_gnt_7", vid_gnt, 1);
        check_eq("t2_we_7", ram_we, 0);
        check_eq("t2_addr_7", ram_addr, 9'h007);
        tick();
        vid_addr = 9'h008;
        #1;
        check_eq("t2_gnt_8", vid_gnt, 1);
        check_eq("t2_we_8", ram_we, 0);
        check_eq("t2_addr_8", ram_addr, 9'h008);
        check_eq("t2_valid_7", vid_rd_valid, 1);
        check_eq("t2_data_7", vid_rd_data, 16'h7007);
        tick();
        vid_addr = 9'h009;
        #1;
        check_eq("t2_gnt_9", vid_gnt, 1);
        check_eq("t2_we_9", ram_we, 0);
        check_eq("t2_data_8", vid_rd_data, 16'h8008);
        tick();
        vid_req = 1'b0;
        #1;
        check_eq("t2_gnt_drop", vid_gnt, 0);
        check_eq("t2_drain1_we", ram_we, 1);
        check_eq("t2_drain1_addr", ram_addr, 9'h010);
        check_eq("t2_drain1_data", ram_wr_data, 16'hA1A1);
        check_eq("t2_valid_9", vid_rd_valid, 1);
        check_eq("t2_data_9", vid_rd_data, 16'h9009);
        tick();
        #1;
        check_eq("t2_drain2_addr", ram_addr, 9'h011);
        check_eq("t2_drain2_data", ram_wr_data, 16'hA2A2);
        check_eq("t2_valid_off", vid_rd_valid, 0);
        tick();
        #1;
        check_eq("t2_status_empty", io_rd_data, 16'h0000);

        // Overflow and CLEAR
        vid_req  = 1'b1;
        vid_addr = 9'h009;
        for (int i = 0; i < 6; i++) begin
            io_wr(16'h4020 + 16'(i), 16'hB000 + 16'(i));
            tick();
        end
        io_idle();
        #1;
        check_eq("t3_status_overflow", io_rd_data, 16'h0284);
        tick();
        io_wr(16'h8001, 16'hFFFF);
        tick();
        io_idle();
        #1;
        check_eq("t3_status_cleared", io_rd_data, 16'h0084);
        tick();

        // Push and pop in the same cycle on a full FIFO
        vid_req = 1'b0;
        io_wr(16'h4030, 16'hC0C0);
        #1;
        check_eq("t5_drain_we", ram_we, 1);
        check_eq("t5_drain_addr", ram_addr, 9'h020);
        check_eq("t5_drain_data", ram_wr_data, 16'hB000);
        tick();
        vid_req = 1'b1;
        io_idle();
        #1;
        check_eq("t5_status_full_nodrop", io_rd_data, 16'h0084);
        check_eq("t5_we_blocked", ram_we, 0);
        tick();

        // Starvation guard: FIFO kept full by a write every cycle
        io_wr(16'h4040, 16'hD0D0);
        last_force = -1;
        n_force    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (ram_we) begin
                check_eq("t4_force_gnt", vid_gnt, 0);
                if (n_force < 4) check_eq("t4_force_addr", ram_addr, force_addr[n_force]);
                if (last_force >= 0) check_eq("t4_force_gap", cyc - last_force, 9);
                last_force = cyc;
                n_force++;
            end
            tick();
        end
        check_eq("t4_force_count", n_force, 4);

        io_idle();
        vid_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        check_eq("t4_status_after_drain", io_rd_data, 16'h2400);
        tick();

        // Reset with queued writes
        vid_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_wr(16'h4050 + 16'(i), 16'hE000 + 16'(i));
            tick();
        end
        io_idle();
        #1;
        check_eq("t6_status_cnt3", io_rd_data, 16'h2403);
        check_eq("t6_we_blocked", ram_we, 0);
        reset = 1'b1;
        #1;
        check_eq("t6_gnt_in_reset", vid_gnt, 1);
        tick();
        reset   = 1'b0;
        vid_req = 1'b0;
        #1;
        check_eq("t6_rd_valid", vid_rd_valid, 0);
        check_eq("t6_status_zero", io_rd_data, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check_eq("t6_no_ram_write", ram_we, 0);
            tick();
        end
        io_addr = 16'h1234;
        #1;
        check_eq("t6_read_other", io_rd_data, 16'h0000);
        io_addr = 16'h4005;
        #1;
        check_eq("t6_read_window", io_rd_data, 16'h0000);
        io_addr = 16'h8001;
        #1;
        check_eq("t6_read_clear", io_rd_data, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_bus_arbiter.md
# sprite_bus_arbiter

Shares the single-port sprite RAM between the stack machine's IO port and the sprite renderer's fetch port. CPU writes into the sprite RAM window are posted into a small write FIFO and drained whenever the renderer is not fetching. A starvation guard forces a drain slot if the FIFO stays full. A status register visible in CPU IO space reports FIFO occupancy and dropped writes.

## Interface
- `CPU_WIDTH`, 16, CPU data and IO address width.
- `DEPTH`, 4, posted-write FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 8, consecutive full-and-blocked cycles before a drain slot is forced.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `io_addr` in CPU_WIDTH: CPU IO address.
- `io_write` in 1: CPU IO write strobe, one cycle.
- `io_wr_data` in CPU_WIDTH: CPU IO write data.
- `io_rd_data` out CPU_WIDTH: CPU IO read data, combinational from `io_addr`.
- `vid_req` in 1: renderer fetch request, level.
- `vid_addr` in 9: renderer fetch address.
- `vid_gnt` out 1: fetch accepted this cycle (combinational).
- `vid_rd_valid` out 1: `vid_rd_data` valid (registered).
- `vid_rd_data` out CPU_WIDTH: fetched word.
- `ram_addr` out 9: sprite RAM address.
- `ram_we` out 1: sprite RAM write enable.
- `ram_wr_data` out CPU_WIDTH: sprite RAM write data.
- `ram_rd_data` in CPU_WIDTH: sprite RAM read data, one-cycle synchronous read.

## Operation
- IO decode. The window is `io_addr[15:9]` == 7'b0100_000, i.e. 0x4000–0x41FF.
  - 0x8000 is STATUS (read-only): [15:8] drop_count, [7] full, [6:4] 0, [3:0] count.
  - 0x8001 is CLEAR: any write zeroes drop_count.
  - All other IO reads return 0. All other writes are ignored.
- Push. `io_write` in the window enqueues {addr[8:0], data}.
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and drop_count increments, saturating at 255.
- Per-cycle slot owner, evaluated combinationally:
  - FORCE: starve_cnt == STARVE_LIMIT and FIFO not empty. The FIFO head is written. `vid_gnt`=0.
  - VIDEO: otherwise, if `vid_req`=1. `vid_gnt`=1, `ram_addr`=`vid_addr`, `ram_we`=0.
  - DRAIN: otherwise, if the FIFO is not empty. `ram_addr`/`ram_wr_data` = head, `ram_we`=1, pop.
  - IDLE: otherwise. `ram_we`=0, `ram_addr`=0.
- starve_cnt:
  - Increments when full and `vid_req`=1 and the slot is not FORCE.
  - Resets to 0 on any pop or when not full.
  - Saturates at STARVE_LIMIT.
- `vid_rd_valid` is the registered `vid_gnt`. `vid_rd_data` = `ram_rd_data` in the cycle `vid_rd_valid`=1.
- count updates by +push −pop. Simultaneous push and pop leaves count unchanged.
- Reset values:
  - count, pointers, drop_count, starve_cnt = 0.
  - `vid_rd_valid`=0.
  - All combinational outputs follow from the reset state: `vid_gnt`=`vid_req`, `ram_we`=0.
  - Reset mid-drain discards all queued writes.

## Timing
- CPU write to RAM write: ≥1 cycle. With the FIFO empty and `vid_req`=0, the RAM write happens in the cycle after `io_write`.
- Video fetch latency: grant in cycle N, data valid in cycle N+1. Back-to-back grants give one word per cycle.
- Worst-case drain delay when full under continuous video requests: STARVE_LIMIT+1 cycles per entry.
- STATUS reads are combinational and reflect the registered state before the current cycle's push/pop.
- A write to CLEAR and a drop in the same cycle leave drop_count = 1.

## Structure
- Shared package holds:
  - the IO map constants (SPRITE_WIN_BASE, STATUS_ADDR, CLEAR_ADDR);
  - the STATUS bit positions;
  - the `CPU_WIDTH` define already used by the CPU.
- One sub-module, `posted_write_fifo`: DEPTH × (9+CPU_WIDTH), with push/pop/count/full/empty and a same-cycle push+pop rule.
- Owner selection, IO decode and counters live in the top level.

## Test plan
- **Idle drain:** `vid_req`=0, write 0x1234 to 0x4005 → next cycle `ram_we`=1, `ram_addr`=5, `ram_wr_data`=0x1234; STATUS count returns to 0.
- **Video priority:** FIFO holds 2 entries, `vid_req`=1 for 3 cycles at addr 7,8,9 → `vid_gnt`=1 each cycle; `ram_we`=0; `vid_rd_valid` follows one cycle later with the RAM contents. Drains resume when `vid_req` drops.
- **Overflow:** `vid_req`=1, 6 window writes with DEPTH=4 → STATUS = 0x0284 (drop_count 2, full, count 4). A write to 0x8001 clears drop_count → STATUS = 0x0084.
- **Starvation guard:** FIFO full, `vid_req` held high → exactly one forced write every STARVE_LIMIT+1 cycles, with `vid_gnt`=0 in that cycle.
- **Push+pop when full:** full FIFO, DRAIN slot and window write in the same cycle → write accepted, count stays 4, no drop.
- **Reset mid-operation:** reset asserted with 3 queued writes → count=0, `vid_rd_valid`=0 next cycle, no RAM writes afterwards; non-window IO reads return 0.
